ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
REQ-002 Port: clk  in  1  clock; all logic on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: in_data  in  8  raw scan-code byte from the upstream PS/2 receiver.
REQ-005 Port: in_valid  in  1  one-cycle strobe; in_data is valid only while in_valid is high.
REQ-006 Port: out_ready  in  1  consumer accepts the head event.
REQ-007 Port: out_valid  out  1  FIFO non-empty.
REQ-008 Port: out_scan  out  8  head event scan code, with prefixes stripped.
REQ-009 Port: out_ext  out  1  head event was E0-prefixed.
REQ-010 Port: out_make  out  1  1 = press, 0 = release.
REQ-011 Port: out_ascii  out  8  head event ASCII code; 0 if the key is unmapped.
REQ-012 Port: key_count  out  8  count of distinct key presses.
REQ-013 Port: shift_on, caps_on, overflow  out  1 each  modifier states and sticky FIFO-drop flag.

Function
REQ-014 Decode FSM states SHALL be IDLE, EXT, BRK and EXT_BRK; state advances only on cycles where in_valid is high.
REQ-015 Transitions:
- IDLE: E0 -> EXT; F0 -> BRK.
- EXT: F0 -> EXT_BRK.
- Any other byte SHALL produce a make event and return to IDLE.
REQ-016 In BRK or EXT_BRK, any byte SHALL produce a break event (ext = 1 iff EXT_BRK) and return to IDLE.
REQ-017 In IDLE, bytes 00, AA, E1, FA, FE and FF SHALL be discarded without an event or state change.
REQ-018 A repeated E0 in EXT, or F0 in BRK or EXT_BRK, SHALL be ignored (state held).
REQ-019 Held-key tracking (held_valid, held_scan, held_ext) SHALL cover one key only.
- A make whose code differs from the held code, or with held_valid = 0, is a new press: key_count +1 and the held register loads.
- A make matching the held code is a typematic repeat: event still pushed, no count.
- A break matching the held code clears held_valid.
REQ-020 key_count SHALL wrap 255 -> 0.
REQ-021 Non-extended 12 or 59:
- make SHALL set shift_on;
- break SHALL clear shift_on.
REQ-022 Non-extended 58 new press (not typematic) SHALL toggle caps_on; its break has no effect.
REQ-023 Modifier and count updates SHALL take effect the cycle after the event byte.
- The pushed event's ASCII uses shift/caps values from before that byte.
REQ-024 ASCII mapping, non-extended only:
- Letters: uppercase iff shift_on XOR caps_on, else lowercase.
- Digits 0-9, space (29) = 20h and enter (5A) = 0Dh: shift has no effect.
- Everything else, including all extended codes, SHALL map to 00.
REQ-025 FIFO latency: event byte strobed at cycle N SHALL give out_valid = 1 at N+1 when the FIFO was empty.
REQ-026 Pop SHALL occur when out_valid && out_ready.
REQ-027 Push SHALL be accepted if the FIFO is not full, or is full with a pop in the same cycle.
- Otherwise the event is dropped and overflow SHALL set and stay set until reset.
REQ-028 Simultaneous push and pop when empty: no pop; push accepted; out_valid = 1 next cycle.
REQ-029 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit to distinguish full from empty.
REQ-030 Outputs SHALL be registered FIFO head contents; values are undefined while out_valid = 0.

Reset
REQ-031 Reset SHALL force:
- state = IDLE;
- FIFO empty;
- out_valid, shift_on, caps_on, overflow, held_valid = 0;
- key_count = 0.
REQ-032 Reset asserted mid-sequence (after E0 or F0) SHALL discard the partial prefix; in_valid is ignored during reset.

Structure
REQ-033 Shared package ps2_pkg SHALL hold:
- the decode state enum;
- prefix constants E0 and F0;
- LSHIFT 12, RSHIFT 59, CAPS 58;
- the ignore-byte list;
- the default FIFO depth.
REQ-034 The combinational sub-module ps2_scan2ascii(scan, ext, upper -> ascii) SHALL implement the REQ-024 table; the FIFO is inline.

Verification
REQ-035 Stimulus 1C then F0 1C -> events {1C, make, 61h} and {1C, break, 61h}; key_count = 1.
REQ-036 Stimulus 12, 1C, F0 1C, F0 12 -> ascii 41h on the A make; shift_on = 1 after 12 and 0 after the final 12.
REQ-037 Stimulus 58, F0 58, 58, 58 (typematic), 1C -> caps_on toggles 1, then 0; the second 58 does not toggle; 1C ascii 61h; key_count = 3.
REQ-038 Stimulus E0 75, E0 F0 75 -> out_ext = 1 on both events, ascii 00; state back at IDLE.
REQ-039 Stimulus: out_ready = 0, 9 make events -> first 8 stored, overflow = 1; then out_ready = 1 drains 8 in order.
REQ-040 Stimulus: F0, reset pulse, 1C -> single make event for 1C.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 key decoder slice: the prefix-decode state
// enum, the special scan-code constants, the list of protocol bytes that never
// produce a key event, the default event FIFO depth and the FIFO entry layout.
// No ports; imported by the decoder top.

package ps2_pkg;

  // Decode states: waiting for a byte, after E0, after F0, after E0 F0
  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  localparam logic [7:0] PREFIX_E0 = 8'hE0;
  localparam logic [7:0] PREFIX_F0 = 8'hF0;

  localparam logic [7:0] LSHIFT = 8'h12;
  localparam logic [7:0] RSHIFT = 8'h59;
  localparam logic [7:0] CAPS   = 8'h58;

  // Keyboard housekeeping bytes (BAT result, ACK, resend, errors, pause prefix)
  localparam int NUM_IGNORE = 6;
  localparam logic [7:0] IGNORE_BYTES [NUM_IGNORE] =
    '{8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF};

  localparam int DEFAULT_FIFO_DEPTH = 8;

  // One decoded key event as stored in the FIFO
  typedef struct packed {
    logic [7:0] scan;
    logic       ext;
    logic       make;
    logic [7:0] ascii;
  } key_event_t;

  function automatic logic is_ignore(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_IGNORE; i++) begin
      if (code == IGNORE_BYTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if
// Bundles the raw scan-byte input strobe and the decoded event output stream.
//   in_data/in_valid : raw byte from the PS/2 receiver, one-cycle strobe
//   out_ready        : consumer accepts the head event
//   out_valid        : an event is available
//   out_scan/out_ext/out_make/out_ascii : head event fields
// The slave modport is the decoder side; master is the producer/consumer side.

interface ps2_key_decoder_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_scan;
  logic       out_ext;
  logic       out_make;
  logic [7:0] out_ascii;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_valid, out_scan, out_ext, out_make, out_ascii
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_valid, out_scan, out_ext, out_make, out_ascii
  );

endinterface

// File: rtl/ps2_key_decoder_scan2ascii.sv
// ps2_scan2ascii
// Combinational scan-code set 2 to ASCII lookup.
//   scan  : scan code with prefixes stripped
//   ext   : code was E0-prefixed (extended codes never map)
//   upper : letters come out uppercase when set
//   ascii : mapped character, 00 when the key has no mapping

module ps2_scan2ascii (
  input  logic [7:0] scan,
  input  logic       ext,
  input  logic       upper,
  output logic [7:0] ascii
);

  logic [7:0] letter;
  logic [7:0] other;

  // Letters are looked up in lowercase; a nonzero result marks a letter key
  // so the case adjustment applies only to those.
  always_comb begin
    letter = 8'h00;
    case (scan)
      8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
      8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
      8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
  end

  // Digits, space and enter ignore the shift/caps state entirely.
  always_comb begin
    other = 8'h00;
    case (scan)
      8'h45: other = 8'h30;  8'h16: other = 8'h31;  8'h1E: other = 8'h32;
      8'h26: other = 8'h33;  8'h25: other = 8'h34;  8'h2E: other = 8'h35;
      8'h36: other = 8'h36;  8'h3D: other = 8'h37;  8'h3E: other = 8'h38;
      8'h46: other = 8'h39;  8'h29: other = 8'h20;  8'h5A: other = 8'h0D;
      default: other = 8'h00;
    endcase
  end

  always_comb begin
    ascii = 8'h00;
    if (!ext) begin
      if (letter != 8'h00) ascii = upper ? (letter - 8'h20) : letter;
      else                 ascii = other;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns raw PS/2 set 2 scan bytes into make/break key events with ASCII,
// tracks shift/caps state and counts distinct key presses. Events are queued
// in an inline FIFO.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of ps2_key_decoder_if (byte input, event output)
//   key_count  : distinct presses, wraps at 256
//   shift_on   : a shift key is down
//   caps_on    : caps lock toggled on
//   overflow   : sticky, an event was dropped on a full FIFO

module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  ps2_key_decoder_if.slave  bus,
  output logic [7:0]        key_count,
  output logic              shift_on,
  output logic              caps_on,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  state_t     state;
  state_t     next_state;
  logic       ev_fire;
  logic       ev_make;
  logic       ev_ext;
  logic [7:0] ev_ascii;

  logic       held_valid;
  logic [7:0] held_scan;
  logic       held_ext;
  logic       is_held;
  logic       new_press;

  key_event_t mem [FIFO_DEPTH];
  key_event_t head;
  key_event_t ev_word;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic       empty;
  logic       full;
  logic       push;
  logic       pop;

  // Decode state register; a partial prefix is thrown away on reset.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Prefix decode: E0/F0 bytes move between states, any other byte closes
  // the sequence with an event. Repeated prefixes hold the current state.
  always_comb begin
    next_state = state;
    ev_fire    = 1'b0;
    ev_make    = 1'b0;
    ev_ext     = 1'b0;
    if (bus.in_valid) begin
      case (state)
        IDLE: begin
          if (bus.in_data == PREFIX_E0)      next_state = EXT;
          else if (bus.in_data == PREFIX_F0) next_state = BRK;
          else if (!is_ignore(bus.in_data)) begin
            ev_fire = 1'b1;
            ev_make = 1'b1;
          end
        end
        EXT: begin
          ev_ext = 1'b1;
          if (bus.in_data == PREFIX_F0) next_state = EXT_BRK;
          else if (bus.in_data != PREFIX_E0) begin
            ev_fire    = 1'b1;
            ev_make    = 1'b1;
            next_state = IDLE;
          end
        end
        BRK: begin
          if (bus.in_data != PREFIX_F0) begin
            ev_fire    = 1'b1;
            next_state = IDLE;
          end
        end
        EXT_BRK: begin
          ev_ext = 1'b1;
          if (bus.in_data != PREFIX_F0) begin
            ev_fire    = 1'b1;
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // A make of the currently held key is typematic repeat, not a new press.
  assign is_held   = held_valid && (held_scan == bus.in_data) && (held_ext == ev_ext);
  assign new_press = ev_fire && ev_make && !is_held;

  // Held key, press counter and modifiers all update the cycle after the
  // event byte, so the ASCII of that event sees the old shift/caps values.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_valid <= 1'b0;
      held_scan  <= 8'h00;
      held_ext   <= 1'b0;
      key_count  <= 8'h00;
      shift_on   <= 1'b0;
      caps_on    <= 1'b0;
    end else begin
      if (new_press) begin
        held_valid <= 1'b1;
        held_scan  <= bus.in_data;
        held_ext   <= ev_ext;
        key_count  <= key_count + 8'd1;
      end else if (ev_fire && !ev_make && is_held) begin
        held_valid <= 1'b0;
      end
      if (ev_fire && !ev_ext && (bus.in_data == LSHIFT || bus.in_data == RSHIFT))
        shift_on <= ev_make;
      if (new_press && !ev_ext && bus.in_data == CAPS)
        caps_on <= ~caps_on;
    end
  end

  ps2_scan2ascii u_scan2ascii (
    .scan  (bus.in_data),
    .ext   (ev_ext),
    .upper (shift_on ^ caps_on),
    .ascii (ev_ascii)
  );

  assign ev_word = '{scan: bus.in_data, ext: ev_ext, make: ev_make, ascii: ev_ascii};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // A push into a full FIFO still succeeds when the head leaves this cycle.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && bus.out_ready;
  assign push  = ev_fire && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (ev_fire && !push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ev_word;
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign bus.out_valid = !empty;
  assign bus.out_scan  = head.scan;
  assign bus.out_ext   = head.ext;
  assign bus.out_make  = head.make;
  assign bus.out_ascii = head.ascii;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Directed bench for ps2_key_decoder: scan-byte sequences with hand-computed
// event fields, modifier states, press counts and FIFO overflow behaviour.

module tb_ps2_key_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] key_count;
  logic       shift_on;
  logic       caps_on;
  logic       overflow;

  int checks;
  int failures;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .key_count (key_count),
    .shift_on  (shift_on),
    .caps_on   (caps_on),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Present one byte for exactly one rising edge; returns on a falling edge.
  task automatic applyStimulus(input logic [7:0] code);
    @(negedge clk);
    bus.in_data  = code;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Check the head event against expectations, then pop it.
  task automatic popEvent(input string tag, input logic [7:0] scan, input logic ext,
                          input logic make, input logic [7:0] ascii);
    checkOutput({tag, ".valid"}, bus.out_valid, 1'b1);
    checkOutput({tag, ".scan"},  bus.out_scan,  scan);
    checkOutput({tag, ".ext"},   bus.out_ext,   ext);
    checkOutput({tag, ".make"},  bus.out_make,  make);
    checkOutput({tag, ".ascii"}, bus.out_ascii, ascii);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] burst [9];
    logic [7:0] burst_ascii [9];
    checks   = 0;
    failures = 0;
    reset         = 1'b1;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    checkOutput("rst.out_valid", bus.out_valid, 1'b0);
    checkOutput("rst.key_count", key_count, 8'd0);
    checkOutput("rst.shift_on",  shift_on,  1'b0);
    checkOutput("rst.caps_on",   caps_on,   1'b0);
    checkOutput("rst.overflow",  overflow,  1'b0);

    // 1C then F0 1C; event visible one cycle after the byte
    applyStimulus(8'h1C);
    checkOutput("a.latency", bus.out_valid, 1'b1);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    checkOutput("a.key_count", key_count, 8'd1);
    popEvent("a.make",  8'h1C, 1'b0, 1'b1, 8'h61);
    popEvent("a.break", 8'h1C, 1'b0, 1'b0, 8'h61);
    checkOutput("a.drained", bus.out_valid, 1'b0);

    // Shift + A
    doReset();
    applyStimulus(8'h12);
    checkOutput("s.shift_set", shift_on, 1'b1);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    checkOutput("s.shift_clr", shift_on, 1'b0);
    checkOutput("s.key_count", key_count, 8'd2);
    popEvent("s.e0", 8'h12, 1'b0, 1'b1, 8'h00);
    popEvent("s.e1", 8'h1C, 1'b0, 1'b1, 8'h41);
    popEvent("s.e2", 8'h1C, 1'b0, 1'b0, 8'h41);
    popEvent("s.e3", 8'h12, 1'b0, 1'b0, 8'h00);

    // Caps toggles on new presses only
    doReset();
    applyStimulus(8'h58);
    checkOutput("c.caps1", caps_on, 1'b1);
    applyStimulus(8'hF0);
    applyStimulus(8'h58);
    checkOutput("c.caps_brk", caps_on, 1'b1);
    applyStimulus(8'h58);
    checkOutput("c.caps0", caps_on, 1'b0);
    applyStimulus(8'h58);
    checkOutput("c.caps_rep", caps_on, 1'b0);
    applyStimulus(8'h1C);
    checkOutput("c.key_count", key_count, 8'd3);
    popEvent("c.e0", 8'h58, 1'b0, 1'b1, 8'h00);
    popEvent("c.e1", 8'h58, 1'b0, 1'b0, 8'h00);
    popEvent("c.e2", 8'h58, 1'b0, 1'b1, 8'h00);
    popEvent("c.e3", 8'h58, 1'b0, 1'b1, 8'h00);
    popEvent("c.e4", 8'h1C, 1'b0, 1'b1, 8'h61);

    // Extended keys, then a plain key proves decode returned to IDLE
    doReset();
    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    applyStimulus(8'h1C);
    popEvent("x.make",  8'h75, 1'b1, 1'b1, 8'h00);
    popEvent("x.break", 8'h75, 1'b1, 1'b0, 8'h00);
    popEvent("x.idle",  8'h1C, 1'b0, 1'b1, 8'h61);

    // Ignored bytes, repeated prefixes
    applyStimulus(8'hAA);
    applyStimulus(8'hFA);
    applyStimulus(8'h00);
    checkOutput("i.no_event", bus.out_valid, 1'b0);
    applyStimulus(8'hE0);
    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    applyStimulus(8'hF0);
    applyStimulus(8'hF0);
    applyStimulus(8'h32);
    popEvent("i.e0e0", 8'h75, 1'b1, 1'b1, 8'h00);
    popEvent("i.f0f0", 8'h32, 1'b0, 1'b0, 8'h62);
    checkOutput("i.drained", bus.out_valid, 1'b0);

    // Digits, enter, space unaffected by shift
    doReset();
    applyStimulus(8'h12);
    applyStimulus(8'h16);
    applyStimulus(8'h5A);
    applyStimulus(8'h29);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    popEvent("d.shift", 8'h12, 1'b0, 1'b1, 8'h00);
    popEvent("d.one",   8'h16, 1'b0, 1'b1, 8'h31);
    popEvent("d.enter", 8'h5A, 1'b0, 1'b1, 8'h0D);
    popEvent("d.space", 8'h29, 1'b0, 1'b1, 8'h20);
    popEvent("d.unsh",  8'h12, 1'b0, 1'b0, 8'h00);

    // Nine makes into an 8-deep FIFO with no consumer
    doReset();
    burst       = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    burst_ascii = '{8'h71, 8'h77, 8'h65, 8'h72, 8'h74, 8'h79, 8'h75, 8'h69, 8'h6F};
    for (int i = 0; i < 8; i++) applyStimulus(burst[i]);
    checkOutput("o.not_yet", overflow, 1'b0);
    applyStimulus(burst[8]);
    checkOutput("o.overflow", overflow, 1'b1);
    for (int i = 0; i < 8; i++) popEvent($sformatf("o.drain%0d", i), burst[i], 1'b0, 1'b1, burst_ascii[i]);
    checkOutput("o.empty", bus.out_valid, 1'b0);
    checkOutput("o.sticky", overflow, 1'b1);

    // Reset mid-prefix discards F0 and ignores a strobe during reset
    doReset();
    applyStimulus(8'hF0);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_data  = 8'h16;
    bus.in_valid = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("r.no_event", bus.out_valid, 1'b0);
    checkOutput("r.key_count", key_count, 8'd0);
    applyStimulus(8'h1C);
    popEvent("r.make", 8'h1C, 1'b0, 1'b1, 8'h61);
    checkOutput("r.single", bus.out_valid, 1'b0);

    // key_count wraps 255 -> 0
    doReset();
    for (int i = 0; i < 255; i++) applyStimulus((i % 2 == 0) ? 8'h1C : 8'h32);
    checkOutput("w.count255", key_count, 8'd255);
    applyStimulus(8'h32);
    checkOutput("w.count0", key_count, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
